// File: rtl/det2x2_seq_unit_if.sv
// Bus bundle for the 2x2 determinant unit: start request, the four matrix
// entries, and the status/result signals returned to the control stage.
interface det2x2_seq_unit_if #(
  parameter int WIDTH = 8
);
  logic                      en;
  logic signed [WIDTH-1:0]   a_in;
  logic signed [WIDTH-1:0]   b_in;
  logic signed [WIDTH-1:0]   c_in;
  logic signed [WIDTH-1:0]   d_in;
  logic                      busy;
  logic                      done;
  logic signed [2*WIDTH:0]   det;
  logic                      singular;

  modport master (
    output en, a_in, b_in, c_in, d_in,
    input  busy, done, det, singular
  );

  modport slave (
    input  en, a_in, b_in, c_in, d_in,
    output busy, done, det, singular
  );
endinterface

// File: rtl/det2x2_seq_unit.sv
// Sequential 2x2 determinant: det = a*d - b*c computed with one shared signed
// multiplier over four cycles (latch, a*d, b*c, subtract). A one-cycle done
// pulse marks det/singular valid; both are held until the next result.
module det2x2_seq_unit #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  det2x2_seq_unit_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MUL_AD = 2'd1,
    MUL_BC = 2'd2,
    SUB    = 2'd3
  } state_t;

  // Widen both products by one bit before subtracting so the difference is exact.
  function automatic logic signed [2*WIDTH:0] diff_ext(
    input logic signed [2*WIDTH-1:0] x,
    input logic signed [2*WIDTH-1:0] y
  );
    logic signed [2*WIDTH:0] xe;
    logic signed [2*WIDTH:0] ye;
    xe = {x[2*WIDTH-1], x};
    ye = {y[2*WIDTH-1], y};
    return xe - ye;
  endfunction

  state_t                    state_q, state_d;
  logic                      ld_ops, ld_ad, ld_bc, ld_det;

  logic signed [WIDTH-1:0]   a_q, b_q, c_q, d_q;
  logic signed [2*WIDTH-1:0] prod_ad_q, prod_bc_q;
  logic signed [2*WIDTH:0]   det_q;
  logic                      sing_q;
  logic                      done_q;

  logic signed [WIDTH-1:0]   mul_x, mul_y;
  logic signed [2*WIDTH-1:0] mul_p;
  logic signed [2*WIDTH:0]   diff;

  // Shared multiplier: a*d in MUL_AD, b*c otherwise.
  always_comb begin
    mul_x = b_q;
    mul_y = c_q;
    if (state_q == MUL_AD) begin
      mul_x = a_q;
      mul_y = d_q;
    end
    mul_p = mul_x * mul_y;
    diff  = diff_ext(prod_ad_q, prod_bc_q);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and per-state load strobes; requests while busy are dropped.
  always_comb begin
    state_d = state_q;
    ld_ops  = 1'b0;
    ld_ad   = 1'b0;
    ld_bc   = 1'b0;
    ld_det  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.en) begin
          ld_ops  = 1'b1;
          state_d = MUL_AD;
        end
      end
      MUL_AD: begin
        ld_ad   = 1'b1;
        state_d = MUL_BC;
      end
      MUL_BC: begin
        ld_bc   = 1'b1;
        state_d = SUB;
      end
      SUB: begin
        ld_det  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand, product and result registers; reset clears all of them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      d_q       <= '0;
      prod_ad_q <= '0;
      prod_bc_q <= '0;
      det_q     <= '0;
      sing_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= ld_det;
      if (ld_ops) begin
        a_q <= bus.a_in;
        b_q <= bus.b_in;
        c_q <= bus.c_in;
        d_q <= bus.d_in;
      end
      if (ld_ad) prod_ad_q <= mul_p;
      if (ld_bc) prod_bc_q <= mul_p;
      if (ld_det) begin
        det_q  <= diff;
        sing_q <= (diff == '0);
      end
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.det      = det_q;
  assign bus.singular = sing_q;

endmodule

// File: tb/tb_det2x2_seq_unit.sv
// Directed bench for det2x2_seq_unit: hand-computed determinants, latency,
// busy window, back-to-back requests, mid-computation reset and ignored en.
module tb_det2x2_seq_unit;

  localparam int WIDTH = 8;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  det2x2_seq_unit_if #(.WIDTH(WIDTH)) bus ();

  det2x2_seq_unit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_in(input int a, input int b, input int c, input int d);
    bus.a_in = a[WIDTH-1:0];
    bus.b_in = b[WIDTH-1:0];
    bus.c_in = c[WIDTH-1:0];
    bus.d_in = d[WIDTH-1:0];
  endtask

  // One request with a single-cycle en; inputs are scrambled after acceptance.
  task automatic run(input string tag, input int a, input int b, input int c,
                     input int d, input int exp_det);
    int nb;
    set_in(a, b, c, d);
    bus.en = 1'b1;
    step();
    bus.en = 1'b0;
    set_in(a + 37, b - 11, c + 5, d - 23);
    nb = 0;
    for (int k = 0; k < 3; k++) begin
      nb += int'(bus.busy);
      chk({tag, "_done_early"}, bus.done, 0);
      step();
    end
    nb += int'(bus.busy);
    chk({tag, "_busy_cycles"}, nb, 3);
    chk({tag, "_done"}, bus.done, 1);
    chk({tag, "_det"}, bus.det, exp_det);
    chk({tag, "_singular"}, bus.singular, (exp_det == 0) ? 1 : 0);
    step();
    chk({tag, "_done_clear"}, bus.done, 0);
    chk({tag, "_det_hold"}, bus.det, exp_det);
  endtask

  initial begin
    int va, vb, vc, vd;
    int exp_q[$];
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    bus.en = 1'b0;
    set_in(0, 0, 0, 0);
    step();
    step();
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_det", bus.det, 0);
    chk("rst_singular", bus.singular, 0);
    rst_n = 1'b1;
    step();

    // Basic, singular and extreme-value determinants.
    run("t1", 3, 2, 1, 4, 10);
    run("t2", 2, 4, 1, 2, 0);
    run("t3a", -128, 127, -128, -128, 32640);
    run("t3b", -128, -128, -128, 127, -32640);
    run("t3c", 127, -128, -128, 127, -255);

    // en held high for 12 cycles with inputs changing every cycle.
    for (int i = 0; i < 12; i++) begin
      va = i + 1;
      vb = 2 * i - 5;
      vc = 3 - i;
      vd = 7 - 2 * i;
      if (i % 4 == 0) exp_q.push_back(va * vd - vb * vc);
      set_in(va, vb, vc, vd);
      bus.en = 1'b1;
      step();
      chk("t4_done", bus.done, (i % 4 == 3) ? 1 : 0);
      if (i % 4 == 3) chk("t4_det", bus.det, exp_q.pop_front());
    end
    bus.en = 1'b0;
    step();
    chk("t4_done_after", bus.done, 0);
    chk("t4_busy_after", bus.busy, 0);

    // Reset while in MUL_BC aborts the request.
    set_in(5, 1, 1, 5);
    bus.en = 1'b1;
    step();
    bus.en = 1'b0;
    step();
    chk("t5_busy_before", bus.busy, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("t5_busy", bus.busy, 0);
    chk("t5_det", bus.det, 0);
    chk("t5_done", bus.done, 0);
    chk("t5_singular", bus.singular, 0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t5_no_done", bus.done, 0);
    end
    run("t5_after", -7, 3, 2, 6, -48);

    // en pulsed while busy is ignored.
    set_in(9, 2, 3, 4);
    bus.en = 1'b1;
    step();
    set_in(1, 1, 1, 100);
    step();
    set_in(-50, 20, 30, 40);
    step();
    bus.en = 1'b0;
    step();
    chk("t6_done", bus.done, 1);
    chk("t6_det", bus.det, 30);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t6_single_done", bus.done, 0);
    end
    chk("t6_det_hold", bus.det, 30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
